sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Two-to-one arbiter that shares a single sram-like bus between the core's instruction and data sram-like ports. It sits between the core and the single-port sram-like to AXI bridge. It grants one master at a time, locks the grant from address handshake to data return, and routes `addr_ok`, `data_ok` and `rdata` back to the owner only. One transaction is in flight at a time.

## Interface
- No parameters; all widths are fixed by the sram-like protocol.
- `clk` in 1 — single clock, all state on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `inst_req`, `inst_wr` in 1 — instruction master request and write flag.
- `inst_size` in 2 — instruction master size.
- `inst_addr`, `inst_wdata` in 32 — instruction master address and write data.
- `inst_addr_ok`, `inst_data_ok` out 1 — handshakes returned to the instruction master.
- `inst_rdata` out 32 — read data to the instruction master.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata` in (1,1,2,32,32) — data master request fields.
- `data_addr_ok`, `data_data_ok` out 1 — handshakes returned to the data master.
- `data_rdata` out 32 — read data to the data master.
- `req`, `wr` out 1 — shared bus request and write flag.
- `size` out 2 — shared bus size.
- `addr`, `wdata` out 32 — shared bus address and write data.
- `addr_ok`, `data_ok` in 1 — shared bus handshakes.
- `rdata` in 32 — shared bus read data.

## Operation
- The block is a three-state FSM: IDLE, ADDR, DATA. A registered `owner` field records the granted master (INST or DATA).
- **IDLE:**
  - The grant is computed combinationally from `inst_req` and `data_req`.
  - The granted master's `req`, `wr`, `size`, `addr` and `wdata` are muxed onto the bus in the same cycle.
  - `addr_ok` is routed to the granted master only.
- **IDLE transitions:**
  - Granted request with `addr_ok`=1 → latch `owner`, go to DATA.
  - Granted request with `addr_ok`=0 → latch `owner`, go to ADDR.
  - No request → stay in IDLE.
- **ADDR:**
  - The grant is locked to `owner`, so the bus fields come only from `owner`.
  - The other master sees `*_addr_ok`=0.
  - On `addr_ok` → go to DATA.
- **DATA:**
  - Bus `req` is 0 and both `*_addr_ok` are 0.
  - `data_ok` is routed to `owner`; on `data_ok` → go to IDLE.
- **Data return:**
  - `rdata` is broadcast to both `inst_rdata` and `data_rdata`.
  - Only the owner's `*_data_ok` pulses, for exactly one cycle per `data_ok`.
- **Stray handshakes:**
  - `data_ok` in IDLE or ADDR is ignored; neither `*_data_ok` asserts.
  - `addr_ok` with bus `req`=0 is ignored.
- **Default grant (macro absent):** fixed priority, data over instruction.
- **Simultaneous requests in IDLE:** the priority rule above decides; the loser simply sees `*_addr_ok`=0 and must hold its request.

## Timing
- Address phase: zero added latency. A granted request with `addr_ok`=1 in IDLE completes its address handshake in the same cycle.
- Back-to-back transactions: the minimum gap is one cycle. After the `data_ok` cycle, the FSM is in IDLE on the next edge and can grant in that cycle.
- A new address is never accepted in the same cycle as `data_ok`.
- **Reset:**
  - State goes to IDLE, `owner` to INST, and the round-robin pointer to INST.
  - While `rst`=1, `req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok` and `data_data_ok` are forced to 0.
- **Reset mid-transaction:** the outstanding transaction is abandoned. A late bus `data_ok` arrives in IDLE and is ignored.
- Bus `wr`, `size`, `addr` and `wdata` are don't-care while `req`=0; they are driven from `owner`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A one-bit `last` register records the master that most recently completed an address handshake.
  - On simultaneous requests in IDLE, the master that is not `last` wins.
  - A single requester always wins.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, data over instruction.
  - The `last` register is not built.

## Structure
- Shared package `sram_like_pkg` holds:
  - the state typedef: IDLE=2'd0, ADDR=2'd1, DATA=2'd2;
  - the owner typedef: OWN_INST=1'b0, OWN_DATA=1'b1;
  - the size constants: SIZE_B=2'd0, SIZE_H=2'd1, SIZE_W=2'd2.
- Sub-module `arb_grant`: a combinational grant select with inputs `inst_req`, `data_req`, `last` and output `grant`. The macro variation lives here; the FSM and the muxes stay in the top.

## Test plan
- **Single instruction read:** `inst_req`=1, `inst_addr`=0xBFC00000, `addr_ok` the same cycle, `data_ok` 3 cycles later with `rdata`=0x3C1D0001 → `inst_addr_ok` 1 cycle; `inst_data_ok` 1 cycle with `inst_rdata`=0x3C1D0001; `data_data_ok` stays 0.
- **Conflict, fixed priority:** `inst_req` and `data_req`=1 simultaneously, `data_addr`=0x80001000, write with `wdata`=0xDEADBEEF → bus `addr`=0x80001000 and `wr`=1 first; the instruction master is served in the cycle after `data_ok`.
- **Conflict, `ARB_ROUND_ROBIN_EN`:** both masters request continuously for 4 transactions → grants alternate DATA, INST, DATA, INST. The first grant is DATA because `last`=INST after reset.
- **Addr_ok backpressure:** `data_req`=1 with `addr_ok` held 0 for 5 cycles while `inst_req` rises in cycle 2 → bus `addr` stays the data address every cycle; `inst_addr_ok` stays 0.
- **Stray handshake:** `data_ok`=1 in IDLE → neither `*_data_ok` asserts and the state stays IDLE.
- **Reset mid-transaction:** `rst` pulsed in DATA, then `data_ok` arrives → no `*_data_ok` pulse; the next `inst_req` is granted normally.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like bus arbiter.
// Contents: FSM state encoding, bus-owner encoding and the access-size codes.
// No logic. Only declarations shared by the arbiter top and its grant select.
package sram_like_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/arb_grant.sv
// Combinational grant select between the instruction and data masters.
// Latency: none, purely combinational. No backpressure; the losing master just holds its request.
// Ports: inst_req, data_req (requests), last (most recent address-handshake owner), grant (winner).
// Macro ARB_ROUND_ROBIN_EN: when defined, on a conflict the master that is not `last` wins.
// Otherwise data has fixed priority over instruction and `last` is ignored.
module arb_grant
   import sram_like_pkg::*;
(
   input  logic   inst_req,
   input  logic   data_req,
   input  owner_t last,
   output owner_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      grant = OWN_INST;
      if (inst_req && data_req) begin
         grant = (last == OWN_INST) ? OWN_DATA : OWN_INST;
      end else if (data_req) begin
         grant = OWN_DATA;
      end
   end
`else
   // Fixed priority build has no use for the history bit.
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      grant = data_req ? OWN_DATA : OWN_INST;
   end
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-to-one arbiter sharing one sram-like bus between the instruction and data ports.
// Latency: zero added cycles; bus fields and addr_ok pass through combinationally.
// Backpressure: the grant is locked from the address handshake until data_ok, and the loser sees addr_ok=0.
// Ports: clk, rst (sync, active high). inst_* and data_* are the master sides.
// req/wr/size/addr/wdata/addr_ok/data_ok/rdata form the shared bus.
// Macro ARB_ROUND_ROBIN_EN selects round-robin grant instead of data-first priority.
module sram_like_arbiter
   import sram_like_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        req,
   output logic        wr,
   output logic [1:0]  size,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata
);

   state_t state_q, state_d;
   owner_t owner_q, owner_d;
   owner_t last_q;
   owner_t grant;
   owner_t sel;
   logic   sel_req;
   logic   addr_hs;
   logic   data_hs;

   arb_grant u_grant (
      .inst_req (inst_req),
      .data_req (data_req),
      .last     (last_q),
      .grant    (grant)
   );

`ifdef ARB_ROUND_ROBIN_EN
   // Remembers who most recently won an address handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= OWN_INST;
      end else if (addr_hs) begin
         last_q <= sel;
      end
   end
`else
   assign last_q = OWN_INST;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWN_INST;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      // Only IDLE arbitrates; afterwards the bus stays locked to the latched owner.
      sel     = (state_q == IDLE) ? grant : owner_q;
      sel_req = (sel == OWN_DATA) ? data_req : inst_req;

      req   = !rst && (state_q != DATA) && sel_req;
      wr    = (sel == OWN_DATA) ? data_wr    : inst_wr;
      size  = (sel == OWN_DATA) ? data_size  : inst_size;
      addr  = (sel == OWN_DATA) ? data_addr  : inst_addr;
      wdata = (sel == OWN_DATA) ? data_wdata : inst_wdata;

      // addr_ok only counts against a live request; data_ok only in DATA.
      addr_hs = req && addr_ok;
      data_hs = !rst && (state_q == DATA) && data_ok;

      inst_addr_ok = addr_hs && (sel == OWN_INST);
      data_addr_ok = addr_hs && (sel == OWN_DATA);
      inst_data_ok = data_hs && (owner_q == OWN_INST);
      data_data_ok = data_hs && (owner_q == OWN_DATA);
      inst_rdata   = rdata;
      data_rdata   = rdata;

      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               owner_d = sel;
               state_d = addr_ok ? DATA : ADDR;
            end
         end
         ADDR: begin
            if (addr_hs) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (data_hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        req, wr;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        addr_ok, data_ok;
   logic [31:0] rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_like_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_wdata   (inst_wdata),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .req          (req),
      .wr           (wr),
      .size         (size),
      .addr         (addr),
      .wdata        (wdata),
      .addr_ok      (addr_ok),
      .data_ok      (data_ok),
      .rdata        (rdata)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   initial begin
      rst = 1'b1;
      inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2;
      inst_addr = 32'h0; inst_wdata = 32'h0;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
      data_addr = 32'h0; data_wdata = 32'h0;
      addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h0;

      // Reset forces every handshake output low even with live inputs.
      tick();
      settle();
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
      chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
      chk("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
      chk("rst_data_data_ok", {31'd0, data_data_ok}, 32'd0);
      tick();
      rst = 1'b0; inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
      tick();

      // Single instruction read.
      inst_req = 1'b1; inst_addr = 32'hBFC00000; addr_ok = 1'b1;
      settle();
      chk("t1_req", {31'd0, req}, 32'd1);
      chk("t1_addr", addr, 32'hBFC00000);
      chk("t1_size", {30'd0, size}, 32'd2);
      chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
      chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
      tick();
      inst_req = 1'b0; addr_ok = 1'b0;
      for (int c = 1; c < 3; c++) begin
         settle();
         chk("t1_wait_req", {31'd0, req}, 32'd0);
         chk("t1_wait_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
         tick();
      end
      data_ok = 1'b1; rdata = 32'h3C1D0001;
      settle();
      chk("t1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
      chk("t1_inst_rdata", inst_rdata, 32'h3C1D0001);
      chk("t1_data_rdata", data_rdata, 32'h3C1D0001);
      chk("t1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
      tick();
      data_ok = 1'b0;
      settle();
      chk("t1_after_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
      tick();

      // Conflict: data wins under both grant rules (last is INST here).
      inst_req = 1'b1; inst_addr = 32'hBFC00004;
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
      addr_ok = 1'b1;
      settle();
      chk("t2_addr", addr, 32'h80001000);
      chk("t2_wr", {31'd0, wr}, 32'd1);
      chk("t2_wdata", wdata, 32'hDEADBEEF);
      chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
      chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
      tick();
      data_req = 1'b0; data_wr = 1'b0;
      settle();
      chk("t2_data_req", {31'd0, req}, 32'd0);
      chk("t2_stray_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
      tick();
      data_ok = 1'b1;
      settle();
      chk("t2_data_data_ok", {31'd0, data_data_ok}, 32'd1);
      chk("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
      chk("t2_no_addr_on_data_ok", {31'd0, inst_addr_ok}, 32'd0);
      tick();
      data_ok = 1'b0;
      settle();
      chk("t2_inst_addr", addr, 32'hBFC00004);
      chk("t2_inst_served", {31'd0, inst_addr_ok}, 32'd1);
      tick();
      data_ok = 1'b1;
      settle();
      chk("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
      tick();

      // Four back-to-back conflicting transactions.
      data_ok = 1'b0; inst_req = 1'b1; data_req = 1'b1; addr_ok = 1'b1;
      data_addr = 32'h80003000; inst_addr = 32'hBFC00008;
      for (int i = 0; i < 4; i++) begin
         logic exp_data;
`ifdef ARB_ROUND_ROBIN_EN
         exp_data = (i % 2) == 0;
`else
         exp_data = 1'b1;
`endif
         data_ok = 1'b0;
         settle();
         chk("t3_data_addr_ok", {31'd0, data_addr_ok}, {31'd0, exp_data});
         chk("t3_inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, ~exp_data});
         chk("t3_addr", addr, exp_data ? 32'h80003000 : 32'hBFC00008);
         tick();
         data_ok = 1'b1;
         settle();
         chk("t3_data_data_ok", {31'd0, data_data_ok}, {31'd0, exp_data});
         chk("t3_inst_data_ok", {31'd0, inst_data_ok}, {31'd0, ~exp_data});
         tick();
      end
      data_ok = 1'b0; inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0;
      tick();

      // addr_ok backpressure: bus stays locked to data while inst rises.
      data_req = 1'b1; data_addr = 32'h80002000; inst_addr = 32'hBFC00010;
      for (int c = 0; c < 5; c++) begin
         if (c >= 2) inst_req = 1'b1;
         settle();
         chk("t4_addr", addr, 32'h80002000);
         chk("t4_req", {31'd0, req}, 32'd1);
         chk("t4_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
         chk("t4_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
         tick();
      end
      addr_ok = 1'b1;
      settle();
      chk("t4_data_addr_ok_hs", {31'd0, data_addr_ok}, 32'd1);
      chk("t4_inst_addr_ok_hs", {31'd0, inst_addr_ok}, 32'd0);
      tick();
      data_req = 1'b0; inst_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b1;
      settle();
      chk("t4_data_data_ok", {31'd0, data_data_ok}, 32'd1);
      tick();
      data_ok = 1'b0;
      tick();

      // Stray data_ok in IDLE is ignored and IDLE still grants immediately.
      data_ok = 1'b1;
      settle();
      chk("t5_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
      chk("t5_data_data_ok", {31'd0, data_data_ok}, 32'd0);
      tick();
      data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC00020; addr_ok = 1'b1;
      settle();
      chk("t5_still_idle", {31'd0, inst_addr_ok}, 32'd1);
      tick();

      // Reset while in DATA; the late data_ok must be dropped.
      inst_req = 1'b0; addr_ok = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; data_ok = 1'b1;
      settle();
      chk("t6_late_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
      chk("t6_late_data_data_ok", {31'd0, data_data_ok}, 32'd0);
      tick();
      data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC00030; addr_ok = 1'b1;
      settle();
      chk("t6_regrant", {31'd0, inst_addr_ok}, 32'd1);
      chk("t6_regrant_addr", addr, 32'hBFC00030);
      tick();
      inst_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b1;
      settle();
      chk("t6_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
      tick();
      data_ok = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
